// File: rtl/flag_gen_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flag_gen_frame_ctrl
// Purpose  : Frame sequencer for flag_generator_blocked. Accepts one image
//            configuration per frame and holds it on config_*. It admits
//            exactly samples*lines*bands input words, then watches the
//            generator output handshake for the last flag. It reports frame
//            completion and flags a sample-count mismatch.
// Options  : `FLAG_GEN_CTRL_TIMEOUT_EN adds a watchdog and the sticky
//            timeout_error output.
// Revision : 1.0 - initial release
// ============================================================================
module flag_gen_frame_ctrl #(
   parameter int MAX_BLOCK_SAMPLE_LOG = 4,
   parameter int MAX_BLOCK_LINE_LOG   = 4,
   parameter int MAX_IMAGE_SAMPLE_LOG = 12,
   parameter int MAX_IMAGE_LINE_LOG   = 12,
   parameter int MAX_IMAGE_BAND_LOG   = 12,
   parameter int TIMEOUT_LOG          = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   // configuration handshake
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic [MAX_BLOCK_SAMPLE_LOG-1:0] cfg_block_samples,
   input  logic [MAX_BLOCK_LINE_LOG-1:0]   cfg_block_lines,
   input  logic [MAX_IMAGE_SAMPLE_LOG-1:0] cfg_image_samples,
   input  logic [MAX_IMAGE_LINE_LOG-1:0]   cfg_image_lines,
   input  logic [MAX_IMAGE_BAND_LOG-1:0]   cfg_image_bands,
   // configuration held for the generator
   output logic [MAX_BLOCK_SAMPLE_LOG-1:0] config_block_samples,
   output logic [MAX_BLOCK_LINE_LOG-1:0]   config_block_lines,
   output logic [MAX_IMAGE_SAMPLE_LOG-1:0] config_image_samples,
   output logic [MAX_IMAGE_LINE_LOG-1:0]   config_image_lines,
   output logic [MAX_IMAGE_BAND_LOG-1:0]   config_image_bands,
   // gated input stream
   input  logic                            src_valid,
   output logic                            src_ready,
   output logic                            gen_valid,
   input  logic                            gen_ready,
   // observed generator output handshake
   input  logic                            mon_valid,
   input  logic                            mon_ready,
   input  logic                            mon_last_i,
   // status
   output logic                            busy,
   output logic                            frame_done,
   output logic                            count_error
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
   ,
   output logic                            timeout_error
`endif
);

   // Widths of the size arithmetic. A field value of all ones means a count
   // of 2^width, so each "+1" term needs one extra bit, and the full image
   // size can reach exactly 2^T, which needs T+1 bits.
   localparam int MIS = MAX_IMAGE_SAMPLE_LOG;
   localparam int MIL = MAX_IMAGE_LINE_LOG;
   localparam int MIB = MAX_IMAGE_BAND_LOG;
   localparam int T   = MIS + MIL + MIB;
   localparam int CW  = T + 1;          // counters and frame total
   localparam int PW  = MIS + MIL + 1;  // samples*lines partial product
   localparam int SW  = MIS + 1;
   localparam int LW  = MIL + 1;
   localparam int BW  = MIB + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL1  = 3'd1,
      S_MUL2  = 3'd2,
      S_FEED  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_in_cnt;
   logic [CW-1:0]   r_out_cnt;
   logic [PW-1:0]   r_prod;
   logic [CW-1:0]   r_total;
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
   logic [TIMEOUT_LOG-1:0] r_wdog;
`endif

   logic [SW-1:0]   w_s1;
   logic [LW-1:0]   w_l1;
   logic [BW-1:0]   w_b1;
   logic [PW-1:0]   w_prod;
   logic [CW-1:0]   w_total;
   logic            w_feed;
   logic            w_drain;
   logic            w_in_xfer;
   logic            w_in_last;
   logic            w_mon_xfer;
   logic            w_input_done;
   logic [CW-1:0]   w_out_next;

   // Counts (value+1) of the latched image geometry. The size product is
   // split over two cycles so that no single path carries a three-way
   // multiply.
   assign w_s1    = SW'(config_image_samples) + SW'(1);
   assign w_l1    = LW'(config_image_lines)   + LW'(1);
   assign w_b1    = BW'(config_image_bands)   + BW'(1);
   assign w_prod  = PW'(w_s1) * PW'(w_l1);
   assign w_total = CW'(r_prod) * CW'(w_b1);

   assign w_feed  = (r_state == S_FEED);
   assign w_drain = (r_state == S_DRAIN);

   // The stream gate is a pure combinational pass-through while feeding.
   // Outside FEED both directions are held low, so word TOTAL+1 can never
   // slip through.
   assign gen_valid = w_feed & src_valid;
   assign src_ready = w_feed & gen_ready;

   assign w_in_xfer  = w_feed & src_valid & gen_ready;
   assign w_in_last  = w_in_xfer && (r_in_cnt == (r_total - CW'(1)));

   // Output words are only attributed to a frame once one is in flight.
   assign w_mon_xfer = (r_state != S_IDLE) & mon_valid & mon_ready;
   assign w_out_next = r_out_cnt + CW'(1);

   // The input side counts as complete when the controller is already
   // draining, or when the final input word transfers in this same cycle.
   assign w_input_done = w_drain | w_in_last;

   // Handshake status decoded directly from the state register.
   assign cfg_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);

   // Frame sequencer: config latch, size computation, input gating,
   // output monitoring and (optionally) the watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state              <= S_IDLE;
         r_in_cnt             <= '0;
         r_out_cnt            <= '0;
         r_prod               <= '0;
         r_total              <= '0;
         config_block_samples <= '0;
         config_block_lines   <= '0;
         config_image_samples <= '0;
         config_image_lines   <= '0;
         config_image_bands   <= '0;
         frame_done           <= 1'b0;
         count_error          <= 1'b0;
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
         r_wdog               <= '0;
         timeout_error        <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               // config_* only ever change here, so they stay stable from
               // one accept to the next.
               if (cfg_valid) begin
                  config_block_samples <= cfg_block_samples;
                  config_block_lines   <= cfg_block_lines;
                  config_image_samples <= cfg_image_samples;
                  config_image_lines   <= cfg_image_lines;
                  config_image_bands   <= cfg_image_bands;
                  r_in_cnt             <= '0;
                  r_out_cnt            <= '0;
                  count_error          <= 1'b0;
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
                  r_wdog               <= '0;
                  timeout_error        <= 1'b0;
`endif
                  r_state              <= S_MUL1;
               end
            end

            S_MUL1: begin
               r_prod  <= w_prod;
               r_state <= S_MUL2;
            end

            S_MUL2: begin
               r_total <= w_total;
               r_state <= S_FEED;
            end

            S_FEED: begin
               if (w_in_xfer) begin
                  r_in_cnt <= r_in_cnt + CW'(1);
               end
               if (w_in_last) begin
                  r_state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               r_state <= S_DRAIN;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Output-side monitor. The last flag ends the frame regardless of
         // input progress. The count must match and the input must be
         // complete, otherwise the error flag sticks.
         if (w_mon_xfer) begin
            r_out_cnt <= w_out_next;
            if (mon_last_i) begin
               frame_done <= 1'b1;
               r_state    <= S_IDLE;
               if ((w_out_next != r_total) || !w_input_done) begin
                  count_error <= 1'b1;
               end
            end else if ((w_feed || w_drain) && (w_out_next >= r_total)) begin
               // Enough words have been seen but no last flag has arrived.
               // Keep waiting for it; the frame is already known to be bad.
               count_error <= 1'b1;
            end
         end

`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
         // Watchdog: restarts on every observed output word and runs only
         // while a frame is feeding or draining. On saturation the frame
         // is abandoned. A real last flag in the same cycle takes
         // precedence because w_mon_xfer clears the count first.
         if (w_mon_xfer) begin
            r_wdog <= '0;
         end else if (w_feed || w_drain) begin
            if (&r_wdog) begin
               timeout_error <= 1'b1;
               frame_done    <= 1'b1;
               r_state       <= S_IDLE;
            end else begin
               r_wdog <= r_wdog + TIMEOUT_LOG'(1);
            end
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flag_gen_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flag_gen_frame_ctrl
// Purpose  : Scoreboard bench for flag_gen_frame_ctrl with a behavioural
//            generator stand-in (FIFO occupancy model) and randomised
//            handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_gen_frame_ctrl;

   localparam int MBS  = 4;
   localparam int MBL  = 4;
   localparam int MIS  = 12;
   localparam int MIL  = 12;
   localparam int MIB  = 12;
   localparam int TLOG = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [MBS-1:0] cfg_block_samples;
   logic [MBL-1:0] cfg_block_lines;
   logic [MIS-1:0] cfg_image_samples;
   logic [MIL-1:0] cfg_image_lines;
   logic [MIB-1:0] cfg_image_bands;
   logic [MBS-1:0] config_block_samples;
   logic [MBL-1:0] config_block_lines;
   logic [MIS-1:0] config_image_samples;
   logic [MIL-1:0] config_image_lines;
   logic [MIB-1:0] config_image_bands;
   logic           src_valid;
   logic           src_ready;
   logic           gen_valid;
   logic           gen_ready;
   logic           mon_valid;
   logic           mon_ready;
   logic           mon_last_i;
   logic           busy;
   logic           frame_done;
   logic           count_error;
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
   logic           timeout_error;
`endif

   flag_gen_frame_ctrl #(
      .MAX_BLOCK_SAMPLE_LOG (MBS),
      .MAX_BLOCK_LINE_LOG   (MBL),
      .MAX_IMAGE_SAMPLE_LOG (MIS),
      .MAX_IMAGE_LINE_LOG   (MIL),
      .MAX_IMAGE_BAND_LOG   (MIB),
      .TIMEOUT_LOG          (TLOG)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cfg_valid            (cfg_valid),
      .cfg_ready            (cfg_ready),
      .cfg_block_samples    (cfg_block_samples),
      .cfg_block_lines      (cfg_block_lines),
      .cfg_image_samples    (cfg_image_samples),
      .cfg_image_lines      (cfg_image_lines),
      .cfg_image_bands      (cfg_image_bands),
      .config_block_samples (config_block_samples),
      .config_block_lines   (config_block_lines),
      .config_image_samples (config_image_samples),
      .config_image_lines   (config_image_lines),
      .config_image_bands   (config_image_bands),
      .src_valid            (src_valid),
      .src_ready            (src_ready),
      .gen_valid            (gen_valid),
      .gen_ready            (gen_ready),
      .mon_valid            (mon_valid),
      .mon_ready            (mon_ready),
      .mon_last_i           (mon_last_i),
      .busy                 (busy),
      .frame_done           (frame_done),
      .count_error          (count_error)
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
      ,
      .timeout_error        (timeout_error)
`endif
   );

   always #5 clk = ~clk;

   // expected outcome of one frame
   typedef struct {
      longint      total;
      bit          err;
      bit          exact;
      bit          tmo;
      logic [63:0] cfgv;
   } exp_t;

   exp_t   sb[$];
   exp_t   be;
   exp_t   me;

   int     checks = 0;
   int     failures = 0;

   // stimulus modes
   int     src_mode = 0;     // 0 always valid, 1 random
   int     gr_mode = 0;      // 0 always ready, 1 toggle, 2 random
   bit     mr_rand = 1'b0;
   int     force_last = 0;   // 0: last flag on the final word
   bit     block_drain = 1'b0;

   // generator stand-in and frame bookkeeping
   int     fifo = 0;
   longint out_sent = 0;
   int     in_frame = 0;
   longint last_at = 0;
   longint cur_total = 0;
   int     acc_cnt = 0;
   int     frames_done = 0;
   bit     prev_fd = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic longint ref_total(input int s, input int l, input int b);
      return longint'(s + 1) * longint'(l + 1) * longint'(b + 1);
   endfunction

   task automatic set_cfg(input int bs, input int bl, input int s, input int l, input int b);
      cfg_block_samples = MBS'(bs);
      cfg_block_lines   = MBL'(bl);
      cfg_image_samples = MIS'(s);
      cfg_image_lines   = MIL'(l);
      cfg_image_bands   = MIB'(b);
   endtask

   // one clock: drive every handshake input just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
      src_valid = (src_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      case (gr_mode)
         0:       gen_ready = 1'b1;
         1:       gen_ready = ~gen_ready;
         default: gen_ready = 1'($urandom_range(1));
      endcase
      mon_valid  = (fifo > 0) && !(block_drain && (longint'(in_frame) >= cur_total));
      mon_ready  = mr_rand ? 1'($urandom_range(1)) : 1'b1;
      mon_last_i = mon_valid && ((out_sent + 1) == last_at);
   endtask

   task automatic reset_outputs_check(input string tag);
      check({tag, "_cfg_ready"},   64'(cfg_ready), 64'd1);
      check({tag, "_busy"},        64'(busy), 64'd0);
      check({tag, "_frame_done"},  64'(frame_done), 64'd0);
      check({tag, "_count_error"}, 64'(count_error), 64'd0);
      check({tag, "_gen_valid"},   64'(gen_valid), 64'd0);
      check({tag, "_src_ready"},   64'(src_ready), 64'd0);
      check({tag, "_config"},      64'({config_block_samples, config_block_lines,
                                        config_image_samples, config_image_lines,
                                        config_image_bands}), 64'd0);
   endtask

   task automatic recover();
      rst = 1'b1;
      cfg_valid = 1'b0;
      force_last = 0;
      block_drain = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_frame(input int bs, input int bl, input int s, input int l,
                            input int b, input int budget);
      int target;
      int acc0;
      target = frames_done + 1;
      acc0 = acc_cnt;
      set_cfg(bs, bl, s, l, b);
      cfg_valid = 1'b1;
      for (int c = 0; c < budget && frames_done < target; c++) begin
         step();
         if (acc_cnt != acc0) cfg_valid = 1'b0;
      end
      if (frames_done < target) begin
         checks++;
         failures++;
         $display("FAIL frame_wait actual=no_frame_done required=frame_done_within_%0d", budget);
         recover();
      end
   endtask

   // Stimulus side: predict the handshakes that the next rising edge will
   // complete. Update the generator model and push expectations on config
   // accept.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         fifo = 0;
         out_sent = 0;
         in_frame = 0;
         sb.delete();
      end else begin
         if (cfg_valid && cfg_ready) begin
            be.total = ref_total(int'(cfg_image_samples), int'(cfg_image_lines),
                                 int'(cfg_image_bands));
            be.err   = (force_last != 0) && (longint'(force_last) != be.total);
            be.exact = !be.err;
            be.tmo   = block_drain;
            be.cfgv  = 64'({cfg_block_samples, cfg_block_lines, cfg_image_samples,
                            cfg_image_lines, cfg_image_bands});
            sb.push_back(be);
            cur_total = be.total;
            last_at   = (force_last != 0) ? longint'(force_last) : be.total;
            in_frame  = 0;
            fifo      = 0;
            out_sent  = 0;
            acc_cnt++;
         end
         if (gen_valid && gen_ready) begin
            in_frame++;
            fifo++;
         end
         if (mon_valid && mon_ready) begin
            out_sent++;
            fifo--;
            if (mon_last_i) fifo = 0;
         end
      end
   end

   // Monitor: on each frame_done, pop the expectation and compare.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_fd) check("frame_done_one_cycle", 64'(frame_done), 64'd0);
         if (frame_done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL frame_done_unexpected actual=1 expected=0");
            end else begin
               me = sb.pop_front();
               check("count_error", 64'(count_error), 64'(me.err));
               if (me.exact) check("admitted_words", 64'(in_frame), 64'(me.total));
               else check("admitted_below_total", 64'(longint'(in_frame) < me.total), 64'd1);
               check("busy_at_done", 64'(busy), 64'd0);
               check("cfg_ready_at_done", 64'(cfg_ready), 64'd1);
               check("gate_closed_at_done", 64'({gen_valid, src_ready}), 64'd0);
               check("config_stable", 64'({config_block_samples, config_block_lines,
                                           config_image_samples, config_image_lines,
                                           config_image_bands}), me.cfgv);
`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
               check("timeout_error", 64'(timeout_error), 64'(me.tmo));
`endif
            end
            frames_done++;
         end
      end
      prev_fd = frame_done;
   end

   initial begin
      #600000;
      $display("FAIL global_time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int acc0;
      int target;
      bit zeroed;

      rst = 1'b1;
      cfg_valid = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      src_valid = 1'b0;
      gen_ready = 1'b0;
      mon_valid = 1'b0;
      mon_ready = 1'b0;
      mon_last_i = 1'b0;
      repeat (2) @(negedge clk);
      reset_outputs_check("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // T1: 7*7*3 = 147 words, free-flowing handshakes
      src_mode = 0; gr_mode = 0; mr_rand = 1'b0;
      run_frame(2, 2, 6, 6, 2, 400);

      // T2: same frame, throttled input and output
      gr_mode = 1; mr_rand = 1'b1;
      run_frame(2, 2, 6, 6, 2, 1000);

      // T3: last flag forced on output 100
      gr_mode = 0; mr_rand = 1'b0; force_last = 100;
      run_frame(2, 2, 6, 6, 2, 400);
      force_last = 0;

      // T4: zero config held valid throughout a full frame
      target = frames_done + 2;
      acc0 = acc_cnt;
      zeroed = 1'b0;
      set_cfg(2, 2, 6, 6, 2);
      cfg_valid = 1'b1;
      for (int c = 0; c < 800 && frames_done < target; c++) begin
         step();
         if (!zeroed && acc_cnt == acc0 + 1) begin
            set_cfg(0, 0, 0, 0, 0);
            zeroed = 1'b1;
         end
         if (acc_cnt >= acc0 + 2) cfg_valid = 1'b0;
      end
      cfg_valid = 1'b0;
      check("t4_accept_count", 64'(acc_cnt - acc0), 64'd2);
      check("t4_frames", 64'(frames_done >= target), 64'd1);

      // T5: reset in the middle of the frame at input word 50
      acc0 = acc_cnt;
      set_cfg(2, 2, 6, 6, 2);
      cfg_valid = 1'b1;
      for (int c = 0; c < 400 && in_frame < 50; c++) begin
         step();
         if (acc_cnt != acc0) cfg_valid = 1'b0;
      end
      check("t5_word_count", 64'(in_frame), 64'd50);
      rst = 1'b1;
      #1;
      reset_outputs_check("midreset");
      step();
      rst = 1'b0;
      run_frame(1, 3, 2, 1, 3, 400);

      // randomised frames
      src_mode = 1; gr_mode = 2; mr_rand = 1'b1;
      for (int f = 0; f < 6; f++) begin
         run_frame(int'($urandom_range(15)), int'($urandom_range(15)),
                   int'($urandom_range(3)), int'($urandom_range(3)),
                   int'($urandom_range(3)), 1500);
      end

`ifdef FLAG_GEN_CTRL_TIMEOUT_EN
      // T6: output withheld once input is complete; the watchdog must end it
      src_mode = 0; gr_mode = 0; mr_rand = 1'b0; block_drain = 1'b1;
      run_frame(1, 1, 1, 1, 1, 400);
      block_drain = 1'b0;
      run_frame(0, 0, 1, 0, 0, 200);
`endif

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
